mem_wb_buffer: RTL and testbench

- Parametrised successor to the single-entry MEM/WB pipeline latch: a DEPTH-entry FIFO buffer between the MEM stage (data cache) and the WB stage (register file).
- Adds a valid/ready handshake, cache-hit gating, flush, write-back data selection, a $zero write guard and a saturating miss-stall counter.
- Lets a WB-side stall and a data-cache miss be absorbed without losing or duplicating instructions.

---
 rtl/mem_wb_buffer.sv | 119 +++++++++++
 tb/tb_mem_wb_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_buffer.sv
// MEM/WB pipeline buffer: a DEPTH-entry FIFO with a valid/ready handshake.
// It also gates entries on a cache hit, supports flush, selects write-back data and counts miss stalls.
module mem_wb_buffer #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int DEPTH      = 2,
  parameter int ZERO_GUARD = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              mem_hit,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [REG_W-1:0]  in_write_reg,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_read_data,
  output logic              out_mem_to_reg,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_write,
  output logic [CNT_W-1:0]  miss_stall_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
    logic [REG_W-1:0]  wreg;
    logic              memToReg;
    logic              regWrite;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             lastHead_q;
  entry_t             inEntry;
  entry_t             head;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   missCnt_q, missCnt_d;
  logic               push, pop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign inEntry = '{alu: in_alu_result, rdata: in_read_data, wreg: in_write_reg,
                     memToReg: in_mem_to_reg, regWrite: in_reg_write};

  assign in_ready  = (count_q < OCC_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & mem_hit & in_ready;
  assign pop       = out_valid & out_ready;

  // While empty, present the last head so data outputs hold instead of showing a stale slot.
  assign head = out_valid ? mem_q[rdPtr_q] : lastHead_q;

  assign out_alu_result = head.alu;
  assign out_read_data  = head.rdata;
  assign out_mem_to_reg = head.memToReg;
  assign wb_write_reg   = head.wreg;
  assign wb_data        = head.memToReg ? head.rdata : head.alu;
  assign wb_reg_write   = out_valid & head.regWrite & ~((ZERO_GUARD != 0) && (head.wreg == '0));
  assign miss_stall_cnt = missCnt_q;

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    missCnt_d = missCnt_q;
    if (in_valid && !mem_hit && (missCnt_q != '1)) begin
      missCnt_d = missCnt_q + 1'b1;
    end
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = nextPtr(wrPtr_q);
      if (pop)  rdPtr_d = nextPtr(rdPtr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      missCnt_q  <= '0;
      lastHead_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      missCnt_q <= missCnt_d;
      if (out_valid) lastHead_q <= mem_q[rdPtr_q];
      if (push && !flush) mem_q[wrPtr_q] <= inEntry;
    end
  end

endmodule

// File: tb/tb_mem_wb_buffer.sv
// Self-checking bench for mem_wb_buffer: a reference model with a scoreboard queue checks two
// instances every cycle (default parameters, and ZERO_GUARD=0 with CNT_W=4).
module tb_mem_wb_buffer;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  wreg;
    logic        memToReg;
    logic        regWrite;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, mem_hit, out_ready;
  logic [31:0] in_alu_result, in_read_data;
  logic [4:0]  in_write_reg;
  logic        in_mem_to_reg, in_reg_write;

  logic        aInReady, aOutValid, aMemToReg, aRegWrite;
  logic [31:0] aAlu, aRdata, aWbData;
  logic [4:0]  aWreg;
  logic [15:0] aMiss;
  logic        bInReady, bOutValid, bMemToReg, bRegWrite;
  logic [31:0] bAlu, bRdata, bWbData;
  logic [4:0]  bWreg;
  logic [3:0]  bMiss;

  exp_t        sbQueue[$];
  int          modelCount = 0;
  int          modelMissA = 0;
  int          modelMissB = 0;
  int          checkCount = 0;
  int          failCount  = 0;

  mem_wb_buffer dutA (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .mem_hit(mem_hit),
    .in_alu_result(in_alu_result), .in_read_data(in_read_data), .in_write_reg(in_write_reg),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_ready(aInReady),
    .out_ready(out_ready), .out_valid(aOutValid), .out_alu_result(aAlu),
    .out_read_data(aRdata), .out_mem_to_reg(aMemToReg), .wb_write_reg(aWreg),
    .wb_data(aWbData), .wb_reg_write(aRegWrite), .miss_stall_cnt(aMiss)
  );

  mem_wb_buffer #(.ZERO_GUARD(0), .CNT_W(4)) dutB (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .mem_hit(mem_hit),
    .in_alu_result(in_alu_result), .in_read_data(in_read_data), .in_write_reg(in_write_reg),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_ready(bInReady),
    .out_ready(out_ready), .out_valid(bOutValid), .out_alu_result(bAlu),
    .out_read_data(bRdata), .out_mem_to_reg(bMemToReg), .wb_write_reg(bWreg),
    .wb_data(bWbData), .wb_reg_write(bRegWrite), .miss_stall_cnt(bMiss)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic hit, input logic [31:0] alu,
                               input logic [31:0] rdata, input logic [4:0] wreg,
                               input logic m2r, input logic rw, input logic oready,
                               input logic fl);
    in_valid = valid; mem_hit = hit; in_alu_result = alu; in_read_data = rdata;
    in_write_reg = wreg; in_mem_to_reg = m2r; in_reg_write = rw; out_ready = oready;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic oready, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(0, 0, 32'h0, 32'h0, 5'd0, 0, 0, oready, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  // Reference model: check the current cycle against the scoreboard head, then advance the model.
  always @(negedge clk) begin
    logic expReady, expValid, popNow, pushNow;
    exp_t hd, ne;
    expReady = (modelCount < 2);
    expValid = (modelCount != 0);
    checkOutput("inReadyA", {31'b0, aInReady}, {31'b0, expReady});
    checkOutput("inReadyB", {31'b0, bInReady}, {31'b0, expReady});
    checkOutput("outValidA", {31'b0, aOutValid}, {31'b0, expValid});
    checkOutput("outValidB", {31'b0, bOutValid}, {31'b0, expValid});
    checkOutput("missCntA", {16'b0, aMiss}, 32'(modelMissA));
    checkOutput("missCntB", {28'b0, bMiss}, 32'(modelMissB));
    if (!expValid) begin
      checkOutput("wbRegWriteEmptyA", {31'b0, aRegWrite}, 32'd0);
      checkOutput("wbRegWriteEmptyB", {31'b0, bRegWrite}, 32'd0);
    end else if (sbQueue.size() == 0) begin
      checkOutput("scoreboardUnderflow", 32'd0, 32'd1);
    end else begin
      hd = sbQueue[0];
      checkOutput("wbDataA", aWbData, hd.memToReg ? hd.rdata : hd.alu);
      checkOutput("wbDataB", bWbData, hd.memToReg ? hd.rdata : hd.alu);
      checkOutput("wbRegA", {27'b0, aWreg}, {27'b0, hd.wreg});
      checkOutput("wbRegB", {27'b0, bWreg}, {27'b0, hd.wreg});
      checkOutput("aluA", aAlu, hd.alu);
      checkOutput("rdataB", bRdata, hd.rdata);
      checkOutput("rdataA", aRdata, hd.rdata);
      checkOutput("aluB", bAlu, hd.alu);
      checkOutput("memToRegA", {31'b0, aMemToReg}, {31'b0, hd.memToReg});
      checkOutput("memToRegB", {31'b0, bMemToReg}, {31'b0, hd.memToReg});
      checkOutput("wbRegWriteA", {31'b0, aRegWrite}, {31'b0, hd.regWrite && (hd.wreg != 5'd0)});
      checkOutput("wbRegWriteB", {31'b0, bRegWrite}, {31'b0, hd.regWrite});
    end
    if (reset) begin
      sbQueue.delete();
      modelCount = 0;
      modelMissA = 0;
      modelMissB = 0;
    end else begin
      if (in_valid && !mem_hit) begin
        if (modelMissA < 65535) modelMissA++;
        if (modelMissB < 15) modelMissB++;
      end
      if (flush) begin
        sbQueue.delete();
        modelCount = 0;
      end else begin
        popNow  = expValid && out_ready;
        pushNow = in_valid && mem_hit && expReady;
        if (popNow && sbQueue.size() > 0) void'(sbQueue.pop_front());
        if (pushNow) begin
          ne = '{alu: in_alu_result, rdata: in_read_data, wreg: in_write_reg,
                 memToReg: in_mem_to_reg, regWrite: in_reg_write};
          sbQueue.push_back(ne);
        end
        modelCount = modelCount + (pushNow ? 1 : 0) - (popNow ? 1 : 0);
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; mem_hit = 1'b0; out_ready = 1'b0;
    in_alu_result = '0; in_read_data = '0; in_write_reg = '0;
    in_mem_to_reg = 1'b0; in_reg_write = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("resetOutValid", {31'b0, aOutValid}, 32'd0);
    checkOutput("resetInReady", {31'b0, aInReady}, 32'd1);
    checkOutput("resetWbData", aWbData, 32'd0);
    checkOutput("resetAlu", aAlu, 32'd0);

    $display("[TB] streaming four entries");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 32'h10 + 32'(i), 32'h0, 5'(i + 1), 0, 1, 1, 0);
    idle(1, 2);

    $display("[TB] WB stall with DEPTH=2");
    applyStimulus(1, 1, 32'h21, 32'h0, 5'd1, 0, 1, 0, 0);
    applyStimulus(1, 1, 32'h22, 32'h0, 5'd2, 0, 1, 0, 0);
    checkOutput("stallFull", {31'b0, aInReady}, 32'd0);
    applyStimulus(1, 1, 32'h23, 32'h0, 5'd3, 0, 1, 0, 0);
    applyStimulus(1, 1, 32'h23, 32'h0, 5'd3, 0, 1, 1, 0);
    checkOutput("stallDrainHead", aWbData, 32'h22);
    applyStimulus(1, 1, 32'h23, 32'h0, 5'd3, 0, 1, 1, 0);
    checkOutput("stallThirdQueued", aWbData, 32'h23);
    idle(1, 2);

    $display("[TB] cache miss then hit");
    doReset();
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 0, 32'h55, 32'hDEADBEEF, 5'd7, 1, 1, 0, 0);
    applyStimulus(1, 1, 32'h55, 32'hDEADBEEF, 5'd7, 1, 1, 0, 0);
    checkOutput("missCount5", {16'b0, aMiss}, 32'd5);
    checkOutput("missLoadData", aWbData, 32'hDEADBEEF);
    idle(1, 2);

    $display("[TB] zero register guard");
    applyStimulus(1, 1, 32'h99, 32'h0, 5'd0, 0, 1, 0, 0);
    checkOutput("zeroOutValid", {31'b0, aOutValid}, 32'd1);
    checkOutput("zeroGuardOn", {31'b0, aRegWrite}, 32'd0);
    checkOutput("zeroGuardOff", {31'b0, bRegWrite}, 32'd1);
    idle(1, 2);

    $display("[TB] flush while full with a simultaneous push");
    applyStimulus(1, 1, 32'h31, 32'h0, 5'd5, 0, 1, 0, 0);
    applyStimulus(1, 1, 32'h32, 32'h0, 5'd6, 0, 1, 0, 0);
    applyStimulus(1, 1, 32'h33, 32'h0, 5'd8, 0, 1, 1, 1);
    checkOutput("flushOutValid", {31'b0, aOutValid}, 32'd0);
    checkOutput("flushInReady", {31'b0, aInReady}, 32'd1);
    idle(1, 3);

    $display("[TB] counter saturation and mid-stream reset");
    doReset();
    for (int i = 0; i < 20; i++)
      applyStimulus(1, 0, 32'h0, 32'h0, 5'd1, 0, 1, 1, 0);
    checkOutput("satCntB", {28'b0, bMiss}, 32'hF);
    checkOutput("satCntA", {16'b0, aMiss}, 32'd20);
    applyStimulus(1, 1, 32'h41, 32'h0, 5'd9, 0, 1, 0, 0);
    applyStimulus(1, 1, 32'h42, 32'h0, 5'd10, 0, 1, 0, 0);
    checkOutput("heldTwo", {31'b0, aInReady}, 32'd0);
    doReset();
    checkOutput("midResetOutValid", {31'b0, aOutValid}, 32'd0);
    checkOutput("midResetCntA", {16'b0, aMiss}, 32'd0);
    checkOutput("midResetCntB", {28'b0, bMiss}, 32'd0);
    checkOutput("midResetData", aWbData, 32'd0);
    idle(1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
